arb_mux_mnton: RTL and testbench

Registered, parametrised M:1 multiplexer for N-bit data. Adds a valid/ready handshake on every input and on the output. Supports two modes: fixed select (driven by S) and round-robin arbitration across requesting inputs. Used in the pipelined datapath wherever several producers share one pipeline-register consumer, such as writeback and forwarding sources. It has one registered output stage.

---
 rtl/arb_mux_mnton_if.sv | 26 ++
 rtl/arb_mux_mnton.sv | 91 +++++++++
 tb/tb_arb_mux_mnton.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/arb_mux_mnton_if.sv
// Handshake bundle for arb_mux_mnton: M packed input channels and one registered output.
// The master side is the producer/consumer environment; the slave side is the mux.
interface arb_mux_mnton_if #(
   parameter int unsigned N = 32,
   parameter int unsigned M = 8
) ();
   localparam int unsigned SW = $clog2(M);

   logic [M*N-1:0] I;
   logic [M-1:0]   v_in;
   logic [M-1:0]   rdy_out;
   logic [N-1:0]   O;
   logic           v_out;
   logic           rdy_in;
   logic [SW-1:0]  grant;

   modport master (
      output I, v_in, rdy_in,
      input  rdy_out, O, v_out, grant
   );

   modport slave (
      input  I, v_in, rdy_in,
      output rdy_out, O, v_out, grant
   );
endinterface

// File: rtl/arb_mux_mnton.sv
// Registered M:1 mux with per-channel valid/ready, fixed-select or round-robin choice,
// and a single output register stage that stalls under downstream backpressure.
module arb_mux_mnton #(
   parameter  int unsigned N  = 32,
   parameter  int unsigned M  = 8,
   localparam int unsigned SW = $clog2(M)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode,
   input  logic [SW-1:0] S,
   input  logic          en,
   arb_mux_mnton_if.slave bus
);

   logic [N-1:0]  data_q;
   logic          valid_q;
   logic [SW-1:0] grant_q;
   logic [SW-1:0] rr_ptr;

   logic          found;
   logic [SW-1:0] chosen;
   logic [N-1:0]  din;
   logic          load;
   int unsigned   idx;

   always_comb begin
      found  = 1'b0;
      chosen = '0;
      idx    = 0;
      if (!mode) begin
         // Out-of-range S never matches any channel, so it never grants.
         for (int unsigned k = 0; k < M; k++) begin
            if (SW'(k) == S && bus.v_in[k]) begin
               found  = 1'b1;
               chosen = S;
            end
         end
      end else begin
         for (int unsigned off = 1; off <= M; off++) begin
            idx = (32'(rr_ptr) + off) % M;
            if (!found && bus.v_in[idx]) begin
               found  = 1'b1;
               chosen = SW'(idx);
            end
         end
      end
   end

   always_comb begin
      din = '0;
      for (int unsigned k = 0; k < M; k++) begin
         if (SW'(k) == chosen) din = bus.I[k*N +: N];
      end
   end

   assign load = !rst && en && found && (!valid_q || bus.rdy_in);

   always_comb begin
      bus.rdy_out = '0;
      for (int unsigned k = 0; k < M; k++) begin
         bus.rdy_out[k] = load && (SW'(k) == chosen);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
         rr_ptr  <= SW'(M - 1);
      end else if (!en) begin
         // Disabling drops any held beat; the arbitration pointer is kept.
         data_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
      end else if (load) begin
         data_q  <= din;
         valid_q <= 1'b1;
         grant_q <= chosen;
         if (mode) rr_ptr <= chosen;
      end else if (valid_q && bus.rdy_in) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.O     = data_q;
   assign bus.v_out = valid_q;
   assign bus.grant = grant_q;

endmodule

// File: tb/tb_arb_mux_mnton.sv
// Directed bench for arb_mux_mnton (N=32, M=8): reset, fixed select sweep, round-robin,
// backpressure, enable drop and mid-stream reset, with hand-computed expectations.
module tb_arb_mux_mnton;
   localparam int unsigned N = 32;
   localparam int unsigned M = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [2:0] S;
   logic       en;
   int         tests = 0;
   int         fails = 0;

   arb_mux_mnton_if #(.N(N), .M(M)) bus ();

   arb_mux_mnton #(.N(N), .M(M)) dut (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .S    (S),
      .en   (en),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] o, input logic v, input logic [2:0] g);
      check({tag, ".O"}, 64'(bus.O), 64'(o));
      check({tag, ".v_out"}, 64'(bus.v_out), 64'(v));
      check({tag, ".grant"}, 64'(bus.grant), 64'(g));
   endtask

   initial begin
      logic [2:0] rr_seq [8];
      rr_seq = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd7};
      for (int k = 0; k < 8; k++) bus.I[k*32 +: 32] = 32'h1000_0000 + 32'(k);

      // 1. reset held two cycles with everything requesting
      rst = 1'b1; en = 1'b1; mode = 1'b0; S = 3'd0;
      bus.v_in = 8'hFF; bus.rdy_in = 1'b1;
      #1;
      check("rst_rdy0", 64'(bus.rdy_out), 64'h0);
      tick();
      check_out("rst_c1", 32'h0, 1'b0, 3'd0);
      check("rst_rdy1", 64'(bus.rdy_out), 64'h0);
      tick();
      check_out("rst_c2", 32'h0, 1'b0, 3'd0);
      check("rst_rdy2", 64'(bus.rdy_out), 64'h0);

      // 2. fixed select sweep
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         S = 3'(k);
         #1;
         check("sel_rdy", 64'(bus.rdy_out), 64'(1) << k);
         tick();
         check_out("sel", 32'h1000_0000 + 32'(k), 1'b1, 3'(k));
      end

      // 3. round-robin from reset over v_in = 1010_0101
      rst = 1'b1;
      tick();
      rst = 1'b0; mode = 1'b1; bus.v_in = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_rdy", 64'(bus.rdy_out), 64'(1) << rr_seq[k]);
         tick();
         check_out("rr", 32'h1000_0000 + 32'(rr_seq[k]), 1'b1, rr_seq[k]);
      end

      // 4. backpressure on a channel-3 beat
      bus.I[3*32 +: 32] = 32'hDEAD_BEEF;
      bus.v_in = 8'b0000_1000;
      #1;
      check("bp_load_rdy", 64'(bus.rdy_out), 64'h08);
      tick();
      check_out("bp_load", 32'hDEAD_BEEF, 1'b1, 3'd3);
      bus.rdy_in = 1'b0; bus.v_in = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("bp_stall_rdy", 64'(bus.rdy_out), 64'h0);
         tick();
         check_out("bp_stall", 32'hDEAD_BEEF, 1'b1, 3'd3);
      end
      bus.rdy_in = 1'b1;
      #1;
      check("bp_resume_rdy", 64'(bus.rdy_out), 64'h10);
      tick();
      check_out("bp_resume", 32'h1000_0004, 1'b1, 3'd4);

      // 5. enable drop while a beat is held
      bus.rdy_in = 1'b0;
      tick();
      check_out("en_hold", 32'h1000_0004, 1'b1, 3'd4);
      en = 1'b0;
      #1;
      check("en_off_rdy", 64'(bus.rdy_out), 64'h0);
      tick();
      check_out("en_off", 32'h0, 1'b0, 3'd0);
      bus.rdy_in = 1'b1;
      #1;
      check("en_off_rdy2", 64'(bus.rdy_out), 64'h0);
      tick();
      check_out("en_off2", 32'h0, 1'b0, 3'd0);
      en = 1'b1;
      #1;
      check("en_on_rdy", 64'(bus.rdy_out), 64'h20);
      tick();
      check_out("en_on", 32'h1000_0005, 1'b1, 3'd5);

      // 6. selected channel idle, drain, then mid-stream reset
      mode = 1'b0; S = 3'd3; bus.v_in = 8'hF7;
      #1;
      check("idle_rdy", 64'(bus.rdy_out), 64'h0);
      tick();
      check("drain.O", 64'(bus.O), 64'h1000_0005);
      check("drain.v_out", 64'(bus.v_out), 64'h0);
      tick();
      check("drain2.v_out", 64'(bus.v_out), 64'h0);
      S = 3'd2;
      #1;
      check("reload_rdy", 64'(bus.rdy_out), 64'h04);
      tick();
      check_out("reload", 32'h1000_0002, 1'b1, 3'd2);
      rst = 1'b1;
      #1;
      check("mrst_rdy", 64'(bus.rdy_out), 64'h0);
      tick();
      check_out("mrst", 32'h0, 1'b0, 3'd0);
      rst = 1'b0; mode = 1'b1; bus.v_in = 8'hFF;
      #1;
      check("post_rst_rdy", 64'(bus.rdy_out), 64'h01);
      tick();
      check_out("post_rst", 32'h1000_0000, 1'b1, 3'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
